// File: rtl/sw_led_ctrl.sv
// sw_led_ctrl: debounced slide switches drive LEDs in one of four display modes.
// Optional SW_LED_CTRL_SEG_EN builds the parity-rise event counter and its hex display.
module sw_led_ctrl #(
   parameter int SW_W       = 8,
   parameter int LED_W      = 16,
   parameter int DEB_CYCLES = 1000,
   parameter int TICK_DIV   = 5000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SW_W-1:0]  sw,
   input  logic [1:0]       mode,
   output logic [LED_W-1:0] ledr,
   output logic [7:0]       seg0,
   output logic [7:0]       seg1
);

   localparam int CNT_W  = $clog2(DEB_CYCLES + 1);
   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int POP_W  = $clog2(SW_W + 1);

   logic [SW_W-1:0]   sync1;
   logic [SW_W-1:0]   sync2;
   logic [SW_W-1:0]   deb;
   logic [CNT_W-1:0]  deb_cnt [SW_W];
   logic              par;
   logic [POP_W-1:0]  pop;
   logic [LED_W-1:0]  therm;
   logic [LED_W-1:0]  pat;
   logic [LED_W-1:0]  led_nxt;
   logic [TICK_W-1:0] tick_cnt;
   logic              tick;

   // Counter reaching DEB_CYCLES-1 with the bit still different means this edge is the
   // DEB_CYCLES-th disagreeing sample, so the new level is taken now.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         for (int i = 0; i < SW_W; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= sw;
         sync2 <= sync1;
         for (int i = 0; i < SW_W; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign par  = ^deb;
   assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

   always_comb begin
      pop = '0;
      for (int i = 0; i < SW_W; i++) pop = pop + POP_W'(deb[i]);
   end

   always_comb begin
      therm = '0;
      for (int k = 0; k < LED_W; k++) therm[k] = (k < int'(pop));
   end

   always_comb begin
      led_nxt = '0;
      case (mode)
         2'd0:    led_nxt[0] = deb[0] ^ deb[1];
         2'd1:    led_nxt[0] = par;
         2'd2:    led_nxt    = therm;
         default: led_nxt    = pat;
      endcase
   end

   // The pattern keeps rotating in every mode so mode 3 resumes where it would have been.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
         pat      <= LED_W'(1);
         ledr     <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         ledr     <= led_nxt;
         if (tick) begin
            if (par) pat <= {pat[0], pat[LED_W-1:1]};
            else     pat <= {pat[LED_W-2:0], pat[LED_W-1]};
         end
      end
   end

`ifdef SW_LED_CTRL_SEG_EN
   logic [7:0] evt;
   logic       par_q;

   function automatic logic [7:0] hex7(input logic [3:0] d);
      case (d)
         4'h0: hex7 = 8'hC0;
         4'h1: hex7 = 8'hF9;
         4'h2: hex7 = 8'hA4;
         4'h3: hex7 = 8'hB0;
         4'h4: hex7 = 8'h99;
         4'h5: hex7 = 8'h92;
         4'h6: hex7 = 8'h82;
         4'h7: hex7 = 8'hF8;
         4'h8: hex7 = 8'h80;
         4'h9: hex7 = 8'h90;
         4'hA: hex7 = 8'h88;
         4'hB: hex7 = 8'h83;
         4'hC: hex7 = 8'hC6;
         4'hD: hex7 = 8'hA1;
         4'hE: hex7 = 8'h86;
         default: hex7 = 8'h8E;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt   <= '0;
         par_q <= 1'b0;
         seg0  <= 8'hC0;
         seg1  <= 8'hC0;
      end else begin
         par_q <= par;
         if (par && !par_q) evt <= evt + 8'd1;
         seg0 <= hex7(evt[3:0]);
         seg1 <= hex7(evt[7:4]);
      end
   end
`else
   assign seg0 = 8'hFF;
   assign seg1 = 8'hFF;
`endif

endmodule

// File: doc/sw_led_ctrl.md
# sw_led_ctrl

Parametrised switch-to-LED controller for the board top level: debounces `SW_W` slide switches and drives `LED_W` LEDs in one of four display modes. The modes are legacy two-switch XOR, full-width parity, popcount thermometer, and a parity-steered rotating pattern. It also counts debounced parity rising edges and shows the count in hex on two seven-segment digits. It replaces the fixed `sw[0]^sw[1]` LED assignment at the board top.

## Interface
- `SW_W`, 8, number of switch inputs; legal range 2..16.
- `LED_W`, 16, number of LED outputs; must satisfy `LED_W >= SW_W + 1`.
- `DEB_CYCLES`, 1000, consecutive stable cycles required to accept a switch change; minimum 1.
- `TICK_DIV`, 5000000, clock cycles per rotate tick in mode 3; minimum 2.

Ports:
- `clk` input 1: single clock for the whole block.
- `rst` input 1: reset, asynchronous, active-high.
- `sw` input `SW_W`: raw switch levels, asynchronous to `clk`.
- `mode` input 2: display mode select, synchronous to `clk`.
- `ledr` output `LED_W`: LED drive, active-high, registered.
- `seg0` output 8: low hex digit of the event count, active-low.
- `seg1` output 8: high hex digit of the event count, active-low.
- Segment bit order for `seg0`/`seg1`: bits 0..6 = a..g, bit 7 = dp.

## Operation
- Synchroniser: each `sw` bit passes through a 2-flop chain. Resets to 0.
- Debouncer, per bit:
  - Holds a stable value and a counter sized `$clog2(DEB_CYCLES+1)`.
  - If the synced bit equals the stable value, the counter clears.
  - Otherwise the counter increments.
  - When the counter would reach `DEB_CYCLES`, the stable value takes the synced bit and the counter clears.
  - A glitch shorter than `DEB_CYCLES` cycles never changes the stable value.
- `deb[SW_W-1:0]` = stable vector; `par` = XOR-reduce(`deb`).
- `ledr` modes (all unused bits 0):
  - Mode 0: `ledr[0] = deb[0]^deb[1]`.
  - Mode 1: `ledr[0] = par`.
  - Mode 2: thermometer; `ledr[k] = 1` for `k < popcount(deb)`. All-off when popcount is 0; `ledr[SW_W-1:0]` all on at full count.
  - Mode 3: `ledr = pat`.
- Pattern register `pat` (`LED_W` bits):
  - Resets to `{{LED_W-1{1'b0}},1'b1}`.
  - On each tick, rotates left by 1 if `par == 0`, right by 1 if `par == 1`. Wraps MSB to LSB and LSB to MSB.
  - `pat` rotates in every mode, not only mode 3.
  - A mode change never resets `pat`.
- Tick counter:
  - Free-running 0..`TICK_DIV-1`, resets to 0.
  - The tick is a one-cycle pulse when the count is `TICK_DIV-1`; the count then wraps to 0.
- Event counter `evt` (8 bits):
  - Resets to 0.
  - Increments by 1 on each debounced `par` 0→1 transition, detected against a registered `par`.
  - Wraps from 255 to 0.
- Seven-segment outputs: `seg0` = hex(`evt[3:0]`), `seg1` = hex(`evt[7:4]`). Standard 0-F glyphs, active-low, dp off (bit 7 = 1).

## Timing
- Reset values:
  - `ledr` = 0.
  - `seg0` = `seg1` = glyph "0", i.e. 8'hC0.
  - `evt` = 0, `pat` = 1, all debounce state 0.
- Switch latency:
  - A `sw` change held steady is accepted into `deb` on the (`DEB_CYCLES`+2)th rising edge after first being sampled.
  - It appears on `ledr` one edge later, for a total of `DEB_CYCLES`+3 edges.
- `evt` updates one edge after `deb` changes; `seg0`/`seg1` are registered and follow one edge after that.
- `mode` changes are reflected on `ledr` at the next edge.
- Tick and parity change in the same cycle: the rotation uses the `par` value from before the edge.
- Several switches accepted in the same cycle: `par` is computed from the complete new vector. At most one `evt` increment results.
- `rst` asserted mid-operation: all state clears immediately, without waiting for a clock edge. Counters restart from 0 after release.

## Configuration
- `SW_LED_CTRL_SEG_EN`:
  - Defined: the event counter, edge detect and hex decoders are built, and behave as above.
  - Undefined: that logic is removed and `seg0`/`seg1` are tied to 8'hFF (all segments off). `ledr` behaviour is unchanged.

## Test plan
- Reset check: assert `rst` while `clk` is stopped. Required: `ledr` = 0, `seg0` = `seg1` = 8'hC0, with no clock edge needed.
- Debounce, with `DEB_CYCLES` = 4 and mode 1:
  - Pulse `sw[0]` high for 3 cycles. Required: `ledr` stays 0.
  - Then hold `sw[0]` high. Required: `ledr[0]` = 1 exactly 7 edges after the change.
- Mode 0 vs mode 1, with `sw` = 8'b0000_0111 settled:
  - Mode 0. Required: `ledr[0]` = 0.
  - Mode 1. Required: `ledr[0]` = 1.
- Mode 2 thermometer, with `sw` = 8'hFF, then 8'h00:
  - Required: `ledr` = 16'h00FF, then 16'h0000.
- Mode 3 rotation, with `TICK_DIV` = 4:
  - With `par` = 0, after 4 ticks. Required: `pat` = 16'h0010.
  - Set `par` = 1, then 5 more ticks. Required: `pat` = 16'h8000, via wrap from bit 0.
- Event wrap, with `SEG_EN` defined:
  - Toggle `sw[0]` to produce 256 parity rises. Required: `evt` returns to 0 and `seg1`/`seg0` show "00".
  - At 26 rises. Required: "1A".
